// File: rtl/bg_pkg.sv
// bg_pkg: shared constants and types for the background fetch and palette
// stages.
//   IMG_W/IMG_H : source background size in pixels (2x upscaled to screen)
//   SCR_W/SCR_H : visible screen area in pixels
//   ADDR_W      : background ROM address width
//   IDX_W       : palette index width
package bg_pkg;

    localparam int IMG_W  = 320;
    localparam int IMG_H  = 240;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;
    localparam int ADDR_W = 17;
    localparam int IDX_W  = 4;

    typedef logic [IDX_W-1:0]  bg_idx_t;
    typedef logic [ADDR_W-1:0] bg_addr_t;

    // Video sideband bundle carried alongside the ROM read.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic vde;
    } sideband_t;

    // Syncs are active-low, so the idle bundle has both syncs high.
    localparam sideband_t SB_IDLE = '{hsync: 1'b1, vsync: 1'b1, vde: 1'b0};

endpackage

// File: rtl/sig_delay.sv
// sig_delay: fixed-depth shift register delay line.
//   clk   : clock
//   rst_n : asynchronous active-low reset; every stage loads RST_VAL
//   d     : input word
//   q     : d delayed by exactly DEPTH clock cycles
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset, not just the output one, so a reset
    // asserted mid-frame cannot leave stale sideband bits to shift out later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take the
            // previous stage's old value, giving a true shift.
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/bg_fetch.sv
// bg_fetch: scrolling background fetch. Maps the 640x480 screen position to
// a 320x240 source pixel (2x upscale, horizontal wrap-around scroll),
// issues the background ROM address, and realigns the VGA sideband with the
// returned ROM data.
//   Clk, Reset_n       : pixel clock, asynchronous active-low reset
//   drawX, drawY       : current screen column / row
//   hsync_in, vsync_in : active-low syncs; vde_in : active-video flag
//   scroll_load/val    : load horizontal scroll offset at frame start
//   scroll_en/step     : auto-scroll by step pixels per frame
//   rom_addr / rom_q   : background ROM address out (registered) / data in
//   bg_index           : palette index, 0 outside active video
//   hsync_out, vsync_out, vde_out : sideband aligned with bg_index
module bg_fetch #(
    parameter int IMG_W   = bg_pkg::IMG_W,
    parameter int IMG_H   = bg_pkg::IMG_H,
    parameter int ROM_LAT = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [9:0]                drawX,
    input  logic [9:0]                drawY,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      vde_in,
    input  logic                      scroll_load,
    input  logic [8:0]                scroll_val,
    input  logic                      scroll_en,
    input  logic [2:0]                scroll_step,
    output logic [bg_pkg::ADDR_W-1:0] rom_addr,
    input  bg_pkg::bg_idx_t           rom_q,
    output bg_pkg::bg_idx_t           bg_index,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      vde_out
);

    import bg_pkg::*;

    localparam int SX_W  = $clog2(IMG_W);
    localparam int SUM_W = 11;

    logic [SX_W-1:0]   scroll_x;
    logic [SX_W-1:0]   scroll_next;
    logic              vs_prev;
    logic              frame_start;

    logic [SUM_W-1:0]  x_sum;
    logic [SUM_W-1:0]  src_x;
    logic [8:0]        src_y;
    logic [SUM_W-1:0]  val_mod;
    logic [SUM_W-1:0]  step_sum;
    logic [SUM_W-1:0]  step_mod;
    logic              in_active;
    bg_addr_t          row_base;
    bg_addr_t          addr_next;

    sideband_t         sb_in;
    sideband_t         sb_out;

    // ---------------- Stage 0: screen -> source coordinates ----------------
    // Inside the active area (drawX>>1) < IMG_W and scroll_x < IMG_W, so the
    // sum stays below 2*IMG_W and one conditional subtract is a full modulo.
    assign x_sum = SUM_W'(drawX[9:1]) + SUM_W'(scroll_x);
    assign src_x = (x_sum >= SUM_W'(IMG_W)) ? x_sum - SUM_W'(IMG_W) : x_sum;
    assign src_y = drawY[9:1];

    if (IMG_W == 320) begin : g_row_shift
        // 320 = 256 + 64: two shifts and an add instead of a multiplier.
        assign row_base = (bg_addr_t'(src_y) << 8) + (bg_addr_t'(src_y) << 6);
    end else begin : g_row_mul
        assign row_base = bg_addr_t'(src_y * IMG_W);
    end

    assign in_active = (drawX < 10'(SCR_W)) && (drawY < 10'(SCR_H)) &&
                       (SUM_W'(src_y) < SUM_W'(IMG_H));
    assign addr_next = in_active ? row_base + bg_addr_t'(src_x) : '0;

    // ---------------- Scroll register, updated only at frame start ---------
    // A 9-bit scroll_val is at most 511 < 2*IMG_W, so one subtract suffices.
    assign val_mod  = (SUM_W'(scroll_val) >= SUM_W'(IMG_W)) ?
                      SUM_W'(scroll_val) - SUM_W'(IMG_W) : SUM_W'(scroll_val);
    assign step_sum = SUM_W'(scroll_x) + SUM_W'(scroll_step);
    assign step_mod = (step_sum >= SUM_W'(IMG_W)) ?
                      step_sum - SUM_W'(IMG_W) : step_sum;

    // vs_prev resets to 0, so a low vsync_in at reset release is not seen
    // as a falling edge.
    assign frame_start = vs_prev & ~vsync_in;

    always_comb begin
        // NOTE: default assigned first so every path drives scroll_next and
        // no latch is inferred.
        scroll_next = scroll_x;
        if (frame_start) begin
            if (scroll_load) begin
                scroll_next = SX_W'(val_mod);
            end else if (scroll_en) begin
                scroll_next = SX_W'(step_mod);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scroll_x <= '0;
            vs_prev  <= 1'b0;
            rom_addr <= '0;
        end else begin
            scroll_x <= scroll_next;
            vs_prev  <= vsync_in;
            rom_addr <= addr_next;
        end
    end

    // ---------------- Sideband realignment ----------------------------------
    // One cycle for the address register plus the ROM read latency.
    assign sb_in = '{hsync: hsync_in, vsync: vsync_in, vde: vde_in};

    sig_delay #(
        .WIDTH   ($bits(sideband_t)),
        .DEPTH   (1 + ROM_LAT),
        .RST_VAL (SB_IDLE)
    ) u_sb_delay (
        .clk   (Clk),
        .rst_n (Reset_n),
        .d     (sb_in),
        .q     (sb_out)
    );

    assign hsync_out = sb_out.hsync;
    assign vsync_out = sb_out.vsync;
    assign vde_out   = sb_out.vde;
    assign bg_index  = sb_out.vde ? rom_q : '0;

endmodule

// File: tb/tb_bg_fetch.sv
// tb_bg_fetch: scoreboard bench for bg_fetch with a latency-2 model ROM.
module tb_bg_fetch;

    localparam int ROM_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic        hsync_in;
    logic        vsync_in;
    logic        vde_in;
    logic        scroll_load;
    logic [8:0]  scroll_val;
    logic        scroll_en;
    logic [2:0]  scroll_step;
    logic [16:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  bg_index;
    logic        hsync_out;
    logic        vsync_out;
    logic        vde_out;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [16:0] addr;
        logic        hs;
    } exp_t;

    exp_t sb[$];

    bg_fetch #(.IMG_W(320), .IMG_H(240), .ROM_LAT(ROM_LAT)) dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .drawX       (drawX),
        .drawY       (drawY),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .vde_in      (vde_in),
        .scroll_load (scroll_load),
        .scroll_val  (scroll_val),
        .scroll_en   (scroll_en),
        .scroll_step (scroll_step),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .bg_index    (bg_index),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .vde_out     (vde_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model ROM contents: an XOR fold of the address nibbles.
    function automatic logic [3:0] rom_word(input logic [16:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]};
    endfunction

    logic [3:0] rom_pipe [ROM_LAT];
    initial for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] = 4'h0;
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation each time the DUT presents active video.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (vde_out === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_vde_out", 32'(vde_out), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("bg_index@%0d", e.addr), 32'(bg_index), 32'(rom_word(e.addr)));
                    check($sformatf("hsync_out@%0d", e.addr), 32'(hsync_out), 32'(e.hs));
                    check($sformatf("vsync_out@%0d", e.addr), 32'(vsync_out), 32'd1);
                end
            end else begin
                check("bg_index_blank", 32'(bg_index), 32'd0);
            end
        end
    end

    // Drive one pixel; rom_addr is checked one clock later.
    task automatic pix(input int x, input int y, input bit hs, input bit vde, input int exp_addr);
        drawX = 10'(x); drawY = 10'(y); hsync_in = hs; vde_in = vde;
        if (vde) sb.push_back('{addr: 17'(exp_addr), hs: hs});
        @(negedge clk);
        check($sformatf("rom_addr(%0d,%0d)", x, y), 32'(rom_addr), 32'(exp_addr));
    endtask

    task automatic idle(input int n);
        vde_in = 1'b0; drawX = 10'd700; drawY = 10'd500; hsync_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // vsync low for low_cycles, then read scroll_x back through rom_addr at (0,0).
    task automatic frame(input int low_cycles, input int exp_scroll, input string name);
        drawX = 10'd0; drawY = 10'd0; vde_in = 1'b0; vsync_in = 1'b0;
        repeat (low_cycles) @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
        check(name, 32'(rom_addr), 32'(exp_scroll));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        drawX = 10'd0; drawY = 10'd0;
        hsync_in = 1'b1; vsync_in = 1'b1; vde_in = 1'b0;
        scroll_load = 1'b0; scroll_val = 9'd0;
        scroll_en = 1'b0; scroll_step = 3'd0;

        repeat (2) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_vde_out", 32'(vde_out), 32'd0);
        check("rst_bg_index", 32'(bg_index), 32'd0);
        check("rst_hsync_out", 32'(hsync_out), 32'd1);
        check("rst_vsync_out", 32'(vsync_out), 32'd1);
        rst_n = 1'b1;

        // Basic mapping with scroll 0, including the screen corners.
        pix(5,   7,   1, 1, 962);
        pix(0,   0,   0, 1, 0);
        pix(639, 479, 1, 1, 76799);
        pix(100, 200, 0, 1, 32050);
        pix(7,   3,   1, 1, 323);
        pix(1,   1,   0, 1, 0);
        idle(5);

        // Sideband latency: single vde pulse must emerge 3 clocks later.
        pix(5, 7, 0, 1, 962);
        vde_in = 1'b0; drawX = 10'd700; drawY = 10'd500; hsync_in = 1'b1;
        lat = 1;
        while (vde_out !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("vde_latency", 32'(lat), 32'd3);
        idle(4);

        // Blanking region addresses are forced to zero.
        pix(640, 10,  1, 0, 0);
        pix(10,  480, 1, 0, 0);
        pix(799, 524, 1, 0, 0);

        // Auto-scroll: one step per vsync fall, long low pulse counts once.
        scroll_en = 1'b1; scroll_step = 3'd4;
        pix(0, 0, 1, 0, 0);
        frame(1, 4,  "scroll_step1");
        frame(3, 8,  "scroll_step2_long_low");
        frame(1, 12, "scroll_step3");

        // Mid-frame load has no effect.
        scroll_load = 1'b1; scroll_val = 9'd100;
        pix(0, 0, 1, 0, 12);
        pix(0, 0, 1, 0, 12);
        scroll_load = 1'b0;

        // Frame start with neither control asserted holds.
        scroll_en = 1'b0;
        frame(1, 12, "scroll_hold");

        // Load wins over auto-scroll.
        scroll_load = 1'b1; scroll_val = 9'd10; scroll_en = 1'b1; scroll_step = 3'd7;
        frame(1, 10, "scroll_priority");
        scroll_en = 1'b0;

        // Wrap-around of the source column.
        scroll_val = 9'd300;
        frame(1, 300, "load_300");
        scroll_load = 1'b0;
        pix(100, 4, 1, 1, 670);
        pix(200, 4, 0, 1, 720);
        idle(4);

        // scroll_val >= IMG_W is reduced.
        scroll_load = 1'b1; scroll_val = 9'd400;
        frame(1, 80, "load_400_mod");
        scroll_val = 9'd319;
        frame(1, 319, "load_319");
        scroll_load = 1'b0;
        pix(2,   0,   1, 1, 0);
        pix(0,   0,   0, 1, 319);
        pix(639, 479, 1, 1, 76798);
        idle(4);

        // Auto-scroll wraps past IMG_W.
        scroll_en = 1'b1; scroll_step = 3'd4;
        frame(1, 3, "scroll_step_wrap");
        scroll_en = 1'b0;

        scroll_load = 1'b1; scroll_val = 9'd511;
        frame(1, 191, "load_511_mod");
        scroll_load = 1'b0;

        // Reset mid-frame while pixels are in flight.
        pix(10, 10, 1, 1, 1796);
        pix(12, 10, 0, 1, 1797);
        pix(14, 10, 1, 1, 1798);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_rom_addr", 32'(rom_addr), 32'd0);
        check("midrst_vde_out", 32'(vde_out), 32'd0);
        check("midrst_bg_index", 32'(bg_index), 32'd0);
        check("midrst_hsync_out", 32'(hsync_out), 32'd1);
        check("midrst_vsync_out", 32'(vsync_out), 32'd1);
        // vsync held low across release with auto-scroll enabled: no frame start.
        scroll_en = 1'b1; scroll_step = 3'd5; vsync_in = 1'b0;
        drawX = 10'd20; drawY = 10'd0; vde_in = 1'b0; hsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("scroll_after_reset", 32'(rom_addr), 32'd10);
        vsync_in = 1'b1; scroll_en = 1'b0;

        // Pipeline runs normally again after release.
        pix(20,  0,   1, 1, 10);
        pix(21,  0,   0, 1, 10);
        pix(600, 300, 1, 1, 48300);
        idle(6);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
